// File: rtl/lut_cfg_pkg.sv
// Shared configuration for the LogicNets neuron truth-table loader:
// default geometry, derived table depth/beat count and the FSM state type.
package lut_cfg_pkg;

    localparam int LUT_IN_BITS  = 7;
    localparam int LUT_OUT_BITS = 2;
    localparam int LUT_PACK     = 4;

    localparam int LUT_DEPTH = 1 << LUT_IN_BITS;
    localparam int LUT_BEATS = LUT_DEPTH / LUT_PACK;

    // Beat counter width; a single-beat table still needs a 1-bit counter.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int LUT_CNT_W = cnt_width(LUT_BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } lut_state_e;

endpackage

// File: rtl/lut_table_writer_ram.sv
// lut_ram_wide_wr: distributed truth-table storage. One write port that
// stores PACK consecutive entries per beat (address = beat index) and one
// single-entry read port with a registered output. rd_clr forces the read
// result to zero so the caller can hide a table that is not yet valid.
module lut_ram_wide_wr
    import lut_cfg_pkg::*;
#(
    parameter int IN_BITS  = LUT_IN_BITS,
    parameter int OUT_BITS = LUT_OUT_BITS,
    parameter int PACK     = LUT_PACK,
    parameter int CNT_W    = cnt_width((1 << IN_BITS) / PACK)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [CNT_W-1:0]         wr_beat,
    input  logic [PACK*OUT_BITS-1:0] wr_data,
    input  logic                     rd_en,
    input  logic                     rd_clr,
    input  logic [IN_BITS-1:0]       rd_addr,
    output logic [OUT_BITS-1:0]      rd_data
);

    localparam int DEPTH = 1 << IN_BITS;

    logic [OUT_BITS-1:0] mem_r [DEPTH];
    logic [OUT_BITS-1:0] rd_data_r;

    // Wide write: one beat fills PACK adjacent entries; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < PACK; j++) begin
                mem_r[IN_BITS'(int'(wr_beat) * PACK + j)] <= wr_data[j*OUT_BITS +: OUT_BITS];
            end
        end
    end

    // Registered read; holds the last result when no lookup is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {OUT_BITS{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= rd_clr ? {OUT_BITS{1'b0}} : mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/lut_table_writer.sv
// lut_table_writer: runtime loader and 1-cycle lookup engine for one neuron
// truth table. Config beats stream in while in LOAD; once the last beat is
// written the table is flagged loaded and lookups return real data.
// Optional build macro: LUT_CHECKSUM_EN enables the running beat checksum;
// without it cfg_checksum is tied to zero.
module lut_table_writer
    import lut_cfg_pkg::*;
#(
    parameter int IN_BITS  = LUT_IN_BITS,
    parameter int OUT_BITS = LUT_OUT_BITS,
    parameter int PACK     = LUT_PACK
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic                     cfg_valid,
    input  logic [PACK*OUT_BITS-1:0] cfg_data,
    output logic                     cfg_ready,
    output logic                     cfg_done,
    output logic                     loaded,
    input  logic                     lk_valid,
    input  logic [IN_BITS-1:0]       lk_addr,
    output logic                     out_valid,
    output logic [OUT_BITS-1:0]      out_data,
    output logic                     err_lookup,
    output logic [15:0]              cfg_checksum
);

    localparam int DEPTH = 1 << IN_BITS;
    localparam int BEATS = DEPTH / PACK;
    localparam int CNT_W = cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    lut_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             cfg_ready_r;
    logic             cfg_done_r;
    logic             loaded_r;
    logic             out_valid_r;
    logic             err_lookup_r;
    logic             accept_s;
    logic             last_s;
    logic             rd_clr_s;

    // Beat handshake: a start in the same cycle always wins over the beat.
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        if (cfg_ready_r && cfg_valid && !cfg_start) begin
            accept_s = 1'b1;
            last_s   = (cnt_r == LAST_BEAT);
        end else begin
            accept_s = 1'b0;
            last_s   = 1'b0;
        end
    end

    // Lookups while the table is incomplete read as zero.
    assign rd_clr_s = !loaded_r;

    // Load-control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            cfg_ready_r <= 1'b0;
            cfg_done_r  <= 1'b0;
            loaded_r    <= 1'b0;
        end else begin
            cfg_done_r <= 1'b0;
            case (state_r)
                IDLE, RUN: begin
                    if (cfg_start) begin
                        state_r     <= LOAD;
                        cnt_r       <= {CNT_W{1'b0}};
                        cfg_ready_r <= 1'b1;
                        loaded_r    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        cnt_r       <= {CNT_W{1'b0}};
                        cfg_ready_r <= 1'b1;
                    end else if (accept_s && last_s) begin
                        state_r     <= RUN;
                        cnt_r       <= {CNT_W{1'b0}};
                        cfg_ready_r <= 1'b0;
                        cfg_done_r  <= 1'b1;
                        loaded_r    <= 1'b1;
                    end else if (accept_s) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    cfg_ready_r <= 1'b0;
                    loaded_r    <= 1'b0;
                end
            endcase
        end
    end

    // Lookup valid pipeline and sticky error for lookups on an unloaded table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            err_lookup_r <= 1'b0;
        end else begin
            out_valid_r <= lk_valid;
            if (lk_valid && !loaded_r) begin
                err_lookup_r <= 1'b1;
            end else if (cfg_start) begin
                err_lookup_r <= 1'b0;
            end else begin
                err_lookup_r <= err_lookup_r;
            end
        end
    end

    lut_ram_wide_wr #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .PACK     (PACK),
        .CNT_W    (CNT_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept_s),
        .wr_beat (cnt_r),
        .wr_data (cfg_data),
        .rd_en   (lk_valid),
        .rd_clr  (rd_clr_s),
        .rd_addr (lk_addr),
        .rd_data (out_data)
    );

`ifdef LUT_CHECKSUM_EN
    logic [15:0] csum_r;

    // Wrap-around sum of accepted beats since the most recent start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_r <= 16'h0000;
        end else if (cfg_start) begin
            csum_r <= 16'h0000;
        end else if (accept_s) begin
            csum_r <= csum_r + 16'(cfg_data);
        end else begin
            csum_r <= csum_r;
        end
    end

    assign cfg_checksum = csum_r;
`else
    assign cfg_checksum = 16'h0000;
`endif

    assign cfg_ready  = cfg_ready_r;
    assign cfg_done   = cfg_done_r;
    assign loaded     = loaded_r;
    assign out_valid  = out_valid_r;
    assign err_lookup = err_lookup_r;

endmodule

// File: tb/tb_lut_table_writer.sv
// Self-checking bench for lut_table_writer: directed scenarios plus random
// loads/lookups, compared every cycle against a table-level reference model.
module tb_lut_table_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        lkv = 1'b0;
    logic [6:0]  addr = 7'd0;

    logic        cfg_ready, cfg_done, loaded, out_valid, err_lookup;
    logic [1:0]  out_data;
    logic [15:0] cfg_checksum;

    int checks = 0;
    int failures = 0;
    int ready_cnt = 0;
    int done_cnt = 0;
    int ov_cnt = 0;

    // reference model state
    logic [1:0]  m_tbl [128];
    logic        m_loading = 1'b0;
    logic        m_loaded = 1'b0;
    logic        m_err = 1'b0;
    logic        m_ov = 1'b0;
    logic [1:0]  m_od = 2'b00;
    logic [15:0] m_sum = 16'h0000;
    int          m_beat = 0;

    lut_table_writer dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (start),
        .cfg_valid    (valid),
        .cfg_data     (data),
        .cfg_ready    (cfg_ready),
        .cfg_done     (cfg_done),
        .loaded       (loaded),
        .lk_valid     (lkv),
        .lk_addr      (addr),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .err_lookup   (err_lookup),
        .cfg_checksum (cfg_checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_csum();
`ifdef LUT_CHECKSUM_EN
        return m_sum;
`else
        return 16'h0000;
`endif
    endfunction

    // Advance one clock: update the model for the coming edge, then compare.
    task automatic tick();
        logic exp_done;
        exp_done = 1'b0;
        if (lkv) m_od = m_loaded ? m_tbl[addr] : 2'b00;
        m_ov = lkv;
        if (lkv && !m_loaded) m_err = 1'b1;
        else if (start) m_err = 1'b0;
        if (start) begin
            m_loading = 1'b1; m_beat = 0; m_loaded = 1'b0; m_sum = 16'h0000;
        end else if (m_loading && valid) begin
            for (int j = 0; j < 4; j++) m_tbl[m_beat*4 + j] = data[j*2 +: 2];
            m_sum = m_sum + {8'h00, data};
            if (m_beat == 31) begin
                m_loading = 1'b0; m_loaded = 1'b1; exp_done = 1'b1; m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("loaded", 32'(loaded), 32'(m_loaded));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_loading));
        chk("cfg_done", 32'(cfg_done), 32'(exp_done));
        chk("err_lookup", 32'(err_lookup), 32'(m_err));
        chk("cfg_checksum", 32'(cfg_checksum), 32'(exp_csum()));
        if (cfg_ready) ready_cnt++;
        if (cfg_done) done_cnt++;
        if (out_valid) ov_cnt++;
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] d,
                         input logic lv, input logic [6:0] la);
        start = s; valid = v; data = d; lkv = lv; addr = la;
        tick();
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(err_lookup), 32'd0);
        chk("rst_checksum", 32'(cfg_checksum), 32'd0);
        m_loading = 1'b0; m_loaded = 1'b0; m_err = 1'b0; m_ov = 1'b0;
        m_od = 2'b00; m_sum = 16'h0000; m_beat = 0;
        start = 1'b0; valid = 1'b0; lkv = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        logic [6:0] la_tab [4];
        logic [1:0] ld_tab [4];
        la_tab[0] = 7'd0; la_tab[1] = 7'd1; la_tab[2] = 7'd6; la_tab[3] = 7'd127;
        ld_tab[0] = 2'b00; ld_tab[1] = 2'b01; ld_tab[2] = 2'b10; ld_tab[3] = 2'b11;

        // power-on reset
        #2;
        async_reset();

        // lookup on an empty table
        drive(1'b0, 1'b0, 8'h00, 1'b1, 7'd5);
        chk("empty_lk_data", 32'(out_data), 32'd0);
        chk("empty_lk_err", 32'(err_lookup), 32'd1);

        // start with a coincident beat in IDLE, then a full load of E4
        ready_cnt = 0; done_cnt = 0;
        drive(1'b1, 1'b1, 8'hE4, 1'b0, 7'd0);
        chk("start_clears_err", 32'(err_lookup), 32'd0);
        for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, 8'hE4, 1'b0, 7'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 7'd0);
        chk("load_ready_cycles", 32'(ready_cnt), 32'd32);
        chk("load_done_pulses", 32'(done_cnt), 32'd1);
        chk("load_loaded", 32'(loaded), 32'd1);
`ifdef LUT_CHECKSUM_EN
        chk("load_checksum", 32'(cfg_checksum), 32'h1C80);
`endif

        // directed lookups
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, la_tab[i]);
            chk("dir_lookup", 32'(out_data), 32'(ld_tab[i]));
        end

        // back-to-back sweep
        ov_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 7'(i));
            chk("sweep_data", 32'(out_data), 32'(i % 4));
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 7'd0);
        chk("sweep_valid_cycles", 32'(ov_cnt), 32'd128);

        // mid-load restart
        done_cnt = 0;
        drive(1'b1, 1'b0, 8'h00, 1'b0, 7'd0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'hFF, 1'b0, 7'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 7'd0);
        for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, 8'h00, 1'b0, 7'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 7'd0);
        chk("restart_done_pulses", 32'(done_cnt), 32'd1);
        chk("restart_checksum", 32'(cfg_checksum), 32'(exp_csum()));
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 7'($urandom_range(0, 127)));
            chk("restart_zero", 32'(out_data), 32'd0);
        end

        // random loads with gaps, lookups during and after the load
        for (int r = 0; r < 4; r++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0, 7'd0);
            guard = 0;
            while (!m_loaded && guard < 400) begin
                drive(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom),
                      ($urandom_range(0, 1) == 1), 7'($urandom_range(0, 127)));
                guard++;
            end
            chk("rand_load_complete", 32'(loaded), 32'd1);
            for (int i = 0; i < 40; i++)
                drive(1'b0, 1'b0, 8'h00, ($urandom_range(0, 3) != 0), 7'($urandom_range(0, 127)));
        end

        // reset asserted during beat 20
        drive(1'b1, 1'b0, 8'h00, 1'b0, 7'd0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 8'($urandom), 1'b0, 7'd0);
        valid = 1'b1; data = 8'h5A;
        async_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 7'd9);
        chk("post_rst_lk_err", 32'(err_lookup), 32'd1);
        chk("post_rst_lk_data", 32'(out_data), 32'd0);
        chk("post_rst_loaded", 32'(loaded), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 7'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
